// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: h/v counters, syncs, frame-rate animation time.
// Optional VGA_SCAN_PIPE_EN adds a second output register stage.
module vga_scan_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int TW       = 12
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [3:0]    cfg_step,
  input  logic          cfg_pause,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [9:0]    x,
  output logic [9:0]    y,
  output logic          frame_start,
  // "time" is a reserved word, so the animation counter is frame_time
  output logic [TW-1:0] frame_time
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_END  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_END  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {OFF, RUN} state_t;

  state_t        state;
  logic [9:0]    h;
  logic [9:0]    v;
  logic [TW-1:0] time_q;
  logic [3:0]    cur_step;
  logic          cur_pause;
  logic [3:0]    pend_step;
  logic          pend_pause;
  logic          pend_flag;

  logic run;
  logic frame_end;
  logic accept;

  assign run       = (state == RUN) && enable;
  assign frame_end = run && (h == H_END) && (v == V_END);
  assign cfg_ready = (state == OFF) || !pend_flag;
  assign accept    = cfg_valid && cfg_ready;

  // run/idle state and raster counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= OFF;
      h     <= '0;
      v     <= '0;
    end else begin
      unique case (state)
        OFF: begin
          h <= '0;
          v <= '0;
          if (enable) state <= RUN;
        end
        RUN: begin
          if (!enable) begin
            state <= OFF;
            h     <= '0;
            v     <= '0;
          end else if (h == H_END) begin
            h <= '0;
            v <= (v == V_END) ? '0 : v + 10'd1;
          end else begin
            h <= h + 10'd1;
          end
        end
      endcase
    end
  end

  // animation time and frame-boundary config handoff
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      time_q     <= '0;
      cur_step   <= 4'd1;
      cur_pause  <= 1'b0;
      pend_step  <= '0;
      pend_pause <= 1'b0;
      pend_flag  <= 1'b0;
    end else begin
      if (frame_end && !cur_pause)
        time_q <= time_q + TW'(cur_step);
      if (accept && state == OFF) begin
        cur_step  <= cfg_step;
        cur_pause <= cfg_pause;
      end else if (frame_end && pend_flag) begin
        cur_step  <= pend_step;
        cur_pause <= pend_pause;
        pend_flag <= 1'b0;
      end
      if (accept && state == RUN) begin
        pend_step  <= cfg_step;
        pend_pause <= cfg_pause;
        pend_flag  <= 1'b1;
      end
    end
  end

  logic          hs_q, vs_q, act_q, fs_q;
  logic [9:0]    x_q, y_q;
  logic [TW-1:0] t_q;

  // first output stage, decoded from the counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      act_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      fs_q  <= 1'b0;
      t_q   <= '0;
    end else begin
      t_q <= time_q;
      if (run) begin
        hs_q  <= !((h >= HS_BEG) && (h < HS_END));
        vs_q  <= !((v >= VS_BEG) && (v < VS_END));
        act_q <= (h < H_VIS) && (v < V_VIS);
        x_q   <= h;
        y_q   <= v;
        fs_q  <= (h == '0) && (v == '0);
      end else begin
        hs_q  <= 1'b1;
        vs_q  <= 1'b1;
        act_q <= 1'b0;
        x_q   <= '0;
        y_q   <= '0;
        fs_q  <= 1'b0;
      end
    end
  end

`ifdef VGA_SCAN_PIPE_EN
  logic          hs_p, vs_p, act_p, fs_p;
  logic [9:0]    x_p, y_p;
  logic [TW-1:0] t_p;

  // second output stage keeps all outputs aligned
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hs_p  <= 1'b1;
      vs_p  <= 1'b1;
      act_p <= 1'b0;
      x_p   <= '0;
      y_p   <= '0;
      fs_p  <= 1'b0;
      t_p   <= '0;
    end else begin
      hs_p  <= hs_q;
      vs_p  <= vs_q;
      act_p <= act_q;
      x_p   <= x_q;
      y_p   <= y_q;
      fs_p  <= fs_q;
      t_p   <= t_q;
    end
  end

  assign hsync       = hs_p;
  assign vsync       = vs_p;
  assign active      = act_p;
  assign x           = x_p;
  assign y           = y_p;
  assign frame_start = fs_p;
  assign frame_time  = t_p;
`else
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign active      = act_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;
  assign frame_time  = t_q;
`endif

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl on a shrunken raster (15x8, 4-bit time).
// Raster-position model plus directed literal checks and random traffic.
module tb_vga_scan_ctrl;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int TWB = 4;
`ifdef VGA_SCAN_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clock = 0;
  logic reset = 1;
  logic enable = 0;
  logic cfg_valid = 0;
  logic cfg_ready;
  logic [3:0] cfg_step = 0;
  logic cfg_pause = 0;
  logic hsync, vsync, active, frame_start;
  logic [9:0] x, y;
  logic [TWB-1:0] frame_time;

  vga_scan_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .TW(TWB)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_step(cfg_step), .cfg_pause(cfg_pause),
    .hsync(hsync), .vsync(vsync), .active(active),
    .x(x), .y(y), .frame_start(frame_start),
    .frame_time(frame_time)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      if (fails < 40)
        $display("FAIL %s got %0d expected %0d", n, got, exp);
    end
  endtask

  typedef struct packed {
    logic hs, vs, act;
    logic [9:0] x, y;
    logic fs;
    logic [3:0] t;
  } out_t;

  function automatic out_t idle(int t);
    out_t o;
    o.hs = 1; o.vs = 1; o.act = 0;
    o.x = 0; o.y = 0; o.fs = 0;
    o.t = 4'(t);
    return o;
  endfunction

  bit mrun, mpause, mpflag, mppause;
  int mpos, mtime, mstep, mpstep;
  out_t e1, e2, ex;

  // model: raster position as a linear index into the frame
  initial begin
    bit running, fe, acc;
    int h, v;
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        mrun = 0; mpos = 0; mtime = 0; mstep = 1; mpause = 0;
        mpflag = 0; mpstep = 0; mppause = 0;
        e1 = idle(0); e2 = idle(0);
      end else begin
        running = mrun && enable;
        acc = cfg_valid && (!mrun || !mpflag);
        fe = running && (mpos == FRAME - 1);
        e2 = e1;
        if (running) begin
          h = mpos % HT;
          v = mpos / HT;
          e1.hs = !(h >= HA + HF && h < HA + HF + HS);
          e1.vs = !(v >= VA + VF && v < VA + VF + VS);
          e1.act = (h < HA) && (v < VA);
          e1.x = 10'(h);
          e1.y = 10'(v);
          e1.fs = (mpos == 0);
          e1.t = 4'(mtime);
        end else begin
          e1 = idle(mtime);
        end
        if (fe && !mpause) mtime = (mtime + mstep) % 16;
        if (acc && !mrun) begin
          mstep = cfg_step; mpause = cfg_pause;
        end
        if (fe && mpflag) begin
          mstep = mpstep; mpause = mppause; mpflag = 0;
        end
        if (acc && mrun) begin
          mpstep = cfg_step; mppause = cfg_pause; mpflag = 1;
        end
        if (!mrun) begin
          mpos = 0;
          if (enable) mrun = 1;
        end else if (!enable) begin
          mrun = 0; mpos = 0;
        end else begin
          mpos = (mpos + 1) % FRAME;
        end
      end
    end
  end

  // per-cycle compare against the model
  always @(negedge clock) begin
    ex = (LAT == 2) ? e2 : e1;
    chk("hsync", hsync, ex.hs);
    chk("vsync", vsync, ex.vs);
    chk("active", active, ex.act);
    chk("x", x, ex.x);
    chk("y", y, ex.y);
    chk("frame_start", frame_start, ex.fs);
    chk("time", frame_time, ex.t);
    chk("cfg_ready", cfg_ready, !mrun || !mpflag);
  end

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!frame_start && n < 300);
    chk("fs_timeout", frame_start, 1);
  endtask

  task automatic wait_xy(int wx, int wy);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(x == 10'(wx) && y == 10'(wy) && enable) && n < 300);
    chk("xy_timeout", {x, y}, {10'(wx), 10'(wy)});
  endtask

  task automatic send(int st, bit pz);
    cfg_valid = 1;
    cfg_step = 4'(st);
    cfg_pause = pz;
    @(negedge clock);
    cfg_valid = 0;
  endtask

  initial begin
    int n, hl, vl, al, hx, offcnt;
    repeat (3) @(negedge clock);
    reset = 0;
    @(negedge clock);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_active", active, 0);
    chk("rst_x", x, 0);
    chk("rst_time", frame_time, 0);
    chk("rst_ready", cfg_ready, 1);

    enable = 1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!frame_start && n < 20);
    chk("en_to_fs", n, LAT + 1);
    chk("time_f0", frame_time, 0);

    n = 0; hl = 0; vl = 0; al = 0; hx = -1;
    do begin
      if (!hsync) begin
        hl++;
        if (hx < 0) hx = int'(x);
      end
      if (!vsync) vl++;
      if (active) al++;
      n++;
      @(negedge clock);
    end while (!frame_start && n < 300);
    chk("frame_period", n, FRAME);
    chk("hsync_low", hl, HS * VT);
    chk("hsync_x", hx, HA + HF);
    chk("vsync_low", vl, VS * HT);
    chk("active_cnt", al, HA * VA);
    chk("time_f1", frame_time, 1);
    wait_fs();
    wait_fs();
    chk("time_f3", frame_time, 3);

    wait_xy(0, 1);
    send(4, 0);
    chk("ready_pend", cfg_ready, 0);
    wait_fs();
    chk("time_old_step", frame_time, 4);
    chk("ready_back", cfg_ready, 1);
    wait_fs();
    chk("time_step4", frame_time, 8);
    wait_fs();
    chk("time_12", frame_time, 12);

    wait_xy(0, 1);
    send(4, 1);
    wait_fs();
    chk("time_wrap16", frame_time, 0);
    wait_fs();
    chk("time_pause1", frame_time, 0);
    wait_xy(0, 1);
    send(15, 0);
    wait_fs();
    chk("time_pause2", frame_time, 0);
    wait_fs();
    chk("time_15", frame_time, 15);
    wait_fs();
    chk("time_wrap30", frame_time, 14);

    wait_xy(5, 2);
    enable = 0;
    @(negedge clock);
    chk("off_hsync", hsync, 1);
    chk("off_active", active, 0);
    chk("off_x", x, 0);
    chk("off_y", y, 0);
    chk("off_time", frame_time, 14);
    repeat (5) @(negedge clock);
    chk("off_time_hold", frame_time, 14);
    enable = 1;
    wait_fs();
    chk("reen_x", x, 0);
    chk("reen_y", y, 0);
    chk("reen_time", frame_time, 14);
    wait_fs();
    chk("reen_step", frame_time, 13);

    wait_xy(0, 1);
    send(7, 0);
    chk("pend7_ready", cfg_ready, 0);
    repeat (3) @(negedge clock);
    #2 reset = 1;
    #1;
    chk("arst_hsync", hsync, 1);
    chk("arst_vsync", vsync, 1);
    chk("arst_active", active, 0);
    chk("arst_x", x, 0);
    chk("arst_y", y, 0);
    chk("arst_fs", frame_start, 0);
    chk("arst_time", frame_time, 0);
    chk("arst_ready", cfg_ready, 1);
    @(negedge clock);
    reset = 0;
    wait_fs();
    chk("post_rst_t0", frame_time, 0);
    wait_fs();
    chk("post_rst_t1", frame_time, 1);
    wait_fs();
    chk("post_rst_t2", frame_time, 2);

    offcnt = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      cfg_valid = ($urandom_range(0, 15) == 0);
      cfg_step = 4'($urandom_range(0, 15));
      cfg_pause = ($urandom_range(0, 3) == 0);
      if (offcnt > 0) begin
        offcnt--;
        enable = (offcnt == 0);
      end else if ($urandom_range(0, 299) == 0) begin
        enable = 0;
        offcnt = $urandom_range(1, 20);
      end
    end
    cfg_valid = 0;
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
